// File: rtl/pre_if_stage.sv
// Pre-IF stage: generates SRAM-like instruction fetch requests, tracks the
// fetch PC and parks redirects (exception, eret, branch) that arrive while no
// handshake is possible so the next fetch goes to the newest redirect target.
module pre_if_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_allow_in,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        exception_valid,
  input  logic        eret_flush,
  input  logic [31:0] exception_address,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  output logic        to_if_valid,
  output logic [31:0] to_if_program_count,
  output logic        to_if_discard
);

  localparam logic [31:0] RESET_PC     = 32'hbfc00000;
  localparam logic [31:0] EXCEPTION_PC = 32'hbfc00380;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic        live_redirect;
  logic [31:0] live_target;
  logic        handshake;
  logic [31:0] redirect_or_pc;

  // Redirect source selection, exception highest, then eret, then branch.
  always_comb begin
    live_redirect = exception_valid | eret_flush | branch_taken;
    live_target   = branch_target;
    if (exception_valid) begin
      live_target = EXCEPTION_PC;
    end else if (eret_flush) begin
      live_target = exception_address;
    end
  end

  // Pending redirect wins over the default PC, live redirect wins over both.
  always_comb begin
    redirect_or_pc = fetch_pc;
    if (live_redirect) begin
      redirect_or_pc = live_target;
    end else if (redirect_valid) begin
      redirect_or_pc = redirect_target;
    end
  end

  // Memory-side and IF-side outputs; reset masks the request immediately.
  always_comb begin
    inst_req            = (state == REQ) && !reset;
    inst_wr             = 1'b0;
    inst_size           = 2'b10;
    inst_addr           = fetch_pc;
    handshake           = inst_req && inst_addr_ok;
    to_if_valid         = handshake;
    to_if_program_count = fetch_pc;
    to_if_discard       = handshake && (redirect_valid || live_redirect);
  end

  // Fetch FSM: PC advance, redirect capture and request sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      fetch_pc        <= RESET_PC;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_allow_in) begin
            fetch_pc       <= redirect_or_pc;
            redirect_valid <= 1'b0;
            state          <= REQ;
          end else if (live_redirect) begin
            redirect_valid  <= 1'b1;
            redirect_target <= live_target;
          end
        end
        REQ: begin
          if (handshake) begin
            if (live_redirect || redirect_valid) begin
              fetch_pc <= redirect_or_pc;
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
            end
            redirect_valid <= 1'b0;
            state          <= if_allow_in ? REQ : IDLE;
          end else if (live_redirect) begin
            redirect_valid  <= 1'b1;
            redirect_target <= live_target;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage: expected accepted fetches are queued by the
// stimulus and checked by an independent monitor when to_if_valid fires.
module tb_pre_if_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_allow_in;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exception_valid;
  logic        eret_flush;
  logic [31:0] exception_address;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        to_if_valid;
  logic [31:0] to_if_program_count;
  logic        to_if_discard;

  typedef struct packed {
    logic [31:0] pc;
    logic        discard;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  pre_if_stage dut (
    .clock               (clock),
    .reset               (reset),
    .if_allow_in         (if_allow_in),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .exception_valid     (exception_valid),
    .eret_flush          (eret_flush),
    .exception_address   (exception_address),
    .inst_req            (inst_req),
    .inst_wr             (inst_wr),
    .inst_size           (inst_size),
    .inst_addr           (inst_addr),
    .inst_addr_ok        (inst_addr_ok),
    .to_if_valid         (to_if_valid),
    .to_if_program_count (to_if_program_count),
    .to_if_discard       (to_if_discard)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic discard);
    exp_q.push_back({pc, discard});
  endtask

  task automatic quiet();
    branch_taken      = 1'b0;
    branch_target     = '0;
    exception_valid   = 1'b0;
    eret_flush        = 1'b0;
    exception_address = '0;
  endtask

  // Two reset cycles with addr_ok high to prove nothing is issued meanwhile.
  task automatic apply_reset();
    reset        = 1'b1;
    if_allow_in  = 1'b1;
    inst_addr_ok = 1'b1;
    quiet();
    @(negedge clock);
    chk("reset_req", {31'd0, inst_req}, 32'd0);
    chk("reset_valid", {31'd0, to_if_valid}, 32'd0);
    chk("reset_discard", {31'd0, to_if_discard}, 32'd0);
    chk("inst_wr", {31'd0, inst_wr}, 32'd0);
    chk("inst_size", {30'd0, inst_size}, 32'd2);
    nxt();
    nxt();
    reset = 1'b0;
  endtask

  // Monitor: every accepted fetch must match the oldest queued expectation.
  always @(negedge clock) begin
    if (to_if_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_fetch: got pc %h expected none", to_if_program_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fetch_pc", to_if_program_count, e.pc);
        chk("fetch_discard", {31'd0, to_if_discard}, {31'd0, e.discard});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    if_allow_in = 1'b0;
    inst_addr_ok = 1'b0;
    quiet();

    // Sequential fetch, addr_ok always high.
    apply_reset();
    @(negedge clock);
    chk("s1_idle_req", {31'd0, inst_req}, 32'd0);
    nxt();
    push(32'hbfc00000, 1'b0);
    @(negedge clock);
    chk("s1_req", {31'd0, inst_req}, 32'd1);
    nxt();
    push(32'hbfc00004, 1'b0);
    nxt();
    push(32'hbfc00008, 1'b0);
    nxt();

    // Stall, late branch, exception+branch.
    apply_reset();
    inst_addr_ok = 1'b0;
    nxt();
    inst_addr_ok = 1'b1;
    push(32'hbfc00000, 1'b0);
    nxt();
    inst_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("s2_stall_req", {31'd0, inst_req}, 32'd1);
      chk("s2_stall_addr", inst_addr, 32'hbfc00004);
      chk("s2_stall_valid", {31'd0, to_if_valid}, 32'd0);
      nxt();
    end
    inst_addr_ok = 1'b1;
    push(32'hbfc00004, 1'b0);
    nxt();
    inst_addr_ok  = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h80001000;
    @(negedge clock);
    chk("s3_pending_addr", inst_addr, 32'hbfc00008);
    nxt();
    quiet();
    inst_addr_ok = 1'b1;
    push(32'hbfc00008, 1'b1);
    nxt();
    inst_addr_ok = 1'b0;
    @(negedge clock);
    chk("s3_branch_addr", inst_addr, 32'h80001000);
    nxt();
    exception_valid = 1'b1;
    branch_taken    = 1'b1;
    branch_target   = 32'h80005000;
    inst_addr_ok    = 1'b1;
    push(32'h80001000, 1'b1);
    nxt();
    quiet();
    @(negedge clock);
    chk("s4_exc_addr", inst_addr, 32'hbfc00380);
    push(32'hbfc00380, 1'b0);
    nxt();
    if_allow_in  = 1'b0;
    inst_addr_ok = 1'b0;
    nxt();

    // Eret while idle with IF blocked, then redirect overwrite in REQ.
    apply_reset();
    if_allow_in       = 1'b0;
    inst_addr_ok      = 1'b0;
    eret_flush        = 1'b1;
    exception_address = 32'h80002000;
    @(negedge clock);
    chk("s5_idle_req0", {31'd0, inst_req}, 32'd0);
    nxt();
    quiet();
    @(negedge clock);
    chk("s5_idle_req1", {31'd0, inst_req}, 32'd0);
    nxt();
    if_allow_in = 1'b1;
    nxt();
    if_allow_in  = 1'b0;
    inst_addr_ok = 1'b1;
    @(negedge clock);
    chk("s5_eret_addr", inst_addr, 32'h80002000);
    push(32'h80002000, 1'b0);
    nxt();
    inst_addr_ok = 1'b0;
    if_allow_in  = 1'b1;
    @(negedge clock);
    chk("s5_back_idle", {31'd0, inst_req}, 32'd0);
    nxt();
    branch_taken  = 1'b1;
    branch_target = 32'h80003000;
    @(negedge clock);
    chk("s5_seq_addr", inst_addr, 32'h80002004);
    nxt();
    branch_target = 32'h80004000;
    nxt();
    quiet();
    inst_addr_ok = 1'b1;
    @(negedge clock);
    chk("s5_held_addr", inst_addr, 32'h80002004);
    push(32'h80002004, 1'b1);
    nxt();
    inst_addr_ok = 1'b0;
    @(negedge clock);
    chk("s5_newest_wins", inst_addr, 32'h80004000);
    chk("s5_req_before_reset", {31'd0, inst_req}, 32'd1);
    nxt();

    // Reset while a request is outstanding.
    apply_reset();
    @(negedge clock);
    chk("s6_idle_req", {31'd0, inst_req}, 32'd0);
    nxt();
    push(32'hbfc00000, 1'b0);
    @(negedge clock);
    chk("s6_first_addr", inst_addr, 32'hbfc00000);
    nxt();
    if_allow_in  = 1'b0;
    inst_addr_ok = 1'b0;
    nxt();
    nxt();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
